// File: rtl/write_buffer_pkg.sv
// Shared types and constants for the posted-write buffer between the store path
// and the main-memory port.
package write_buffer_pkg;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int BLK_LSB   = 4;
  localparam int DEPTH_DEF = 4;

  localparam logic [ADDR_W-1:0] BLK_MASK = ~((ADDR_W'(1) << BLK_LSB) - ADDR_W'(1));

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic blk_eq(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return ((a ^ b) & BLK_MASK) == '0;
  endfunction
endpackage

// File: rtl/write_buffer_ptr.sv
// Circular-buffer pointer with an extra wrap bit above the index bits.
module wb_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);
  logic [W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst)        r_ptr <= '0;
    else if (i_inc) r_ptr <= r_ptr + W'(1);
  end

  assign o_ptr = r_ptr;
endmodule

// File: rtl/write_buffer.sv
// Posted-write FIFO: single-cycle store accept, store coalescing into the youngest
// entry, one-per-grant drain to memory and a block-address conflict check.
module write_buffer
  import write_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [CW-1:0]     o_count,
  output logic              o_overflow,
  input  logic              i_mem_grant,
  output logic              o_mem_en,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic [ADDR_W-1:0] i_chk_addr,
  output logic              o_chk_hit
);
  localparam int PW = CW - 1;

  wb_entry_t        r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [CW-1:0]    r_count;
  logic             r_full, r_empty, r_overflow;

  logic [PW:0]   w_head, w_tail, w_tail_m1;
  logic [PW-1:0] w_head_idx, w_tail_idx, w_young_idx;
  logic          w_pop, w_push, w_coal, w_drop;
  logic [CW-1:0] w_count_nxt;

  wb_ptr #(.W(PW + 1)) u_head (.clk(clk), .rst(rst), .i_inc(w_pop),  .o_ptr(w_head));
  wb_ptr #(.W(PW + 1)) u_tail (.clk(clk), .rst(rst), .i_inc(w_push), .o_ptr(w_tail));

  assign w_tail_m1   = w_tail - (PW + 1)'(1);
  assign w_head_idx  = w_head[PW-1:0];
  assign w_tail_idx  = w_tail[PW-1:0];
  assign w_young_idx = w_tail_m1[PW-1:0];

  assign w_pop = i_mem_grant & ~r_empty;

  // Never merge into an entry leaving this cycle; the store would be lost.
  assign w_coal = i_wr_en && (r_count != '0)
                  && (r_mem[w_young_idx].addr[ADDR_W-1:1] == i_wr_addr[ADDR_W-1:1])
                  && !(w_pop && (w_head == w_tail_m1));

  assign w_push      = i_wr_en & ~r_full & ~w_coal;
  assign w_drop      = i_wr_en &  r_full & ~w_coal;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_valid    <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      if (w_drop) r_overflow <= 1'b1;
      if (w_push) r_valid[w_tail_idx] <= 1'b1;
      if (w_pop)  r_valid[w_head_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)      r_mem[w_tail_idx]       <= '{addr: i_wr_addr, data: i_wr_data};
    else if (w_coal) r_mem[w_young_idx].data <= i_wr_data;
  end

  always_comb begin
    o_chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (r_valid[i] && blk_eq(r_mem[i].addr, i_chk_addr)) o_chk_hit = 1'b1;
  end

  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_mem_en   = w_pop;
  assign o_mem_wr   = w_pop;
  assign o_mem_addr = r_mem[w_head_idx].addr;
  assign o_mem_data = r_mem[w_head_idx].data;
endmodule
